shift_scheduler: RTL and testbench

Sequencing and arbitration controller for the CORDIC datapath's 16-bit arithmetic right-shift resource. Two requesters share a single shift-by-one stage: the X and Y micro-rotation paths, requester 0 and requester 1. Each request carries an operand and a shift amount. The block grants requesters round-robin, then applies the one-bit arithmetic shift once per clock until the amount is exhausted. It returns the result over a valid/ready response channel tagged with the requester id.

---
 rtl/shift_scheduler_if.sv | 32 +++
 rtl/shift_scheduler.sv | 109 ++++++++++
 tb/tb_shift_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_scheduler_if.sv
// rtl/shift_scheduler_if.sv - request/response bundle between two requesters and the shift scheduler
interface shift_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_shamt;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_shamt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req0_valid, req0_data, req0_shamt,
        output req1_valid, req1_data, req1_shamt,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req0_valid, req0_data, req0_shamt,
        input  req1_valid, req1_data, req1_shamt,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/shift_scheduler.sv
// rtl/shift_scheduler.sv - round-robin scheduler for a shared 1-bit arithmetic right-shift stage
// Optional macro SHIFT_ROUND_EN: round-half-up on the last bit shifted out.
module shift_scheduler #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_scheduler_if.slave    bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             pri_q, pri_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             rdy0, rdy1;
    logic             acc0, acc1;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shamt;
`ifdef SHIFT_ROUND_EN
    logic             guard_q, guard_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            id_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SHIFT_ROUND_EN
            guard_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT_ROUND_EN
            guard_q <= guard_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        id_d      = id_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`ifdef SHIFT_ROUND_EN
        guard_d   = guard_q;
`endif
        acc0      = bus.req0_valid & rdy0;
        acc1      = bus.req1_valid & rdy1;
        // The ready rules guarantee at most one accept, so a plain mux suffices.
        sel_data  = acc1 ? bus.req1_data  : bus.req0_data;
        sel_shamt = acc1 ? bus.req1_shamt : bus.req0_shamt;
        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    acc_d   = sel_data;
                    id_d    = acc1;
                    cnt_d   = (sel_shamt >= CNT_MAX) ? CNT_MAX : sel_shamt;
`ifdef SHIFT_ROUND_EN
                    guard_d = 1'b0;
`endif
                    state_d = (sel_shamt == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
`ifdef SHIFT_ROUND_EN
                guard_d = acc_q[0];
`endif
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    pri_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy0          = (state_q == IDLE) && (!pri_q || !bus.req1_valid);
        rdy1          = (state_q == IDLE) && ( pri_q || !bus.req0_valid);
        bus.req0_ready = rdy0;
        bus.req1_ready = rdy1;
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_id     = id_q;
`ifdef SHIFT_ROUND_EN
        bus.rsp_data   = acc_q + WIDTH'(guard_q);
`else
        bus.rsp_data   = acc_q;
`endif
        busy           = (state_q != IDLE);
    end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb/tb_shift_scheduler.sv - directed self-checking bench for shift_scheduler
module tb_shift_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;

    shift_scheduler_if #(.WIDTH(16), .SHW(4)) bus ();

    shift_scheduler #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_shamt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_shamt = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    // One transaction from a lone requester with rsp_ready held high.
    // exp_lat counts clock edges from the accept edge to the edge that raises rsp_valid.
    task automatic send(input int who, input logic [15:0] d, input logic [3:0] sh,
                        input logic [15:0] exp_d, input int exp_lat, input string tag);
        int w;
        int lat;
        if (who == 1) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_shamt = sh;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_shamt = sh;
        end
        bus.rsp_ready = 1'b1;
        #1;
        w = 0;
        while (!(who == 1 ? bus.req1_ready : bus.req0_ready) && w < 20) begin
            step();
            w++;
        end
        check({tag, "_grant"}, {31'b0, (w < 20)}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_data"}, {16'b0, bus.rsp_data}, {16'b0, exp_d});
        check({tag, "_id"}, {31'b0, bus.rsp_id}, who);
        step();
        check({tag, "_done"}, {30'b0, bus.rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        int          w;
        int          stray;
        clear_inputs();
        #1;
        check("rst_outputs", {14'b0, bus.rsp_valid, busy, bus.rsp_data}, 32'd0);
        check("rst_id", {31'b0, bus.rsp_id}, 32'd0);
        check("rst_ready", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd3);
        do_reset();

        send(0, 16'h8000, 4'd3, 16'hF000, 3, "basic");
        send(1, 16'h1234, 4'd0, 16'h1234, 0, "zero");
        send(1, 16'h5678, 4'd0, 16'h5678, 0, "sole1");
        send(0, 16'h8123, 4'd15, 16'hFFFF, 15, "max_neg");
        send(0, 16'h0123, 4'd15, 16'h0000, 15, "max_pos");

        // Arbitration from reset: both requesters hold valid, grants must alternate.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h0100; bus.req0_shamt = 4'd4;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h0200; bus.req1_shamt = 4'd4;
        bus.rsp_ready  = 1'b1;
        #1;
        check("arb_tie_ready", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!bus.rsp_valid && w < 40) begin
                step();
                w++;
            end
            check("arb_timeout", {31'b0, (w < 40)}, 32'd1);
            check("arb_id", {31'b0, bus.rsp_id}, k & 1);
            check("arb_data", {16'b0, bus.rsp_data}, (k & 1) ? 32'h0020 : 32'h0010);
            step();
        end
        clear_inputs();
        step();

        // Backpressure: response held, queued req0 must wait for handshake plus an IDLE cycle.
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4000; bus.req0_shamt = 4'd2;
        bus.rsp_ready  = 1'b0;
        #1;
        check("bp_ready_idle", {31'b0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_data = 16'h0800; bus.req0_shamt = 4'd1;
        w = 0;
        while (!bus.rsp_valid && w < 40) begin
            step();
            w++;
        end
        check("bp_lat", w, 32'd2);
        held = bus.rsp_data;
        check("bp_data", {16'b0, held}, 32'h1000);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", {13'b0, bus.rsp_valid, bus.req0_ready, bus.rsp_id, bus.rsp_data},
                  {13'b0, 1'b1, 1'b0, 1'b0, held});
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready", {31'b0, bus.req0_ready}, 32'd0);
        step();
        check("bp_bubble", {30'b0, bus.rsp_valid, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        check("bp_accept_busy", {31'b0, busy}, 32'd1);
        w = 0;
        while (!bus.rsp_valid && w < 40) begin
            step();
            w++;
        end
        check("bp_second_lat", w, 32'd1);
        check("bp_second_data", {16'b0, bus.rsp_data}, 32'h0400);
        step();
        clear_inputs();

`ifdef SHIFT_ROUND_EN
        send(0, 16'h0003, 4'd1, 16'h0002, 1, "round_pos");
        send(0, 16'hFFFD, 4'd1, 16'hFFFF, 1, "round_neg");
`else
        send(0, 16'h0003, 4'd1, 16'h0001, 1, "trunc_pos");
        send(0, 16'hFFFD, 4'd1, 16'hFFFE, 1, "trunc_neg");
`endif

        // Reset in the middle of a long shift; pri ends at 1 beforehand so the tie check is meaningful.
        bus.req0_valid = 1'b1; bus.req0_data = 16'h8000; bus.req0_shamt = 4'd8;
        bus.rsp_ready  = 1'b1;
        #1;
        check("rst_mid_grant", {31'b0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        check("rst_mid_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_async", {14'b0, bus.rsp_valid, busy, bus.rsp_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.rsp_valid) stray++;
        end
        check("rst_no_rsp", stray, 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("rst_tie_req0", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd2);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
